// File: rtl/tcp_handshake_initiator.sv
// Client-side TCP three-way handshake: SYN out, matching SYN-ACK in, final ACK out.
// Latency: SYN valid the cycle after start is accepted; ACK valid the cycle after an accepted SYN-ACK.
// Backpressure: tx header held stable while tcp_parser_tx_val & !parser_tcp_tx_rdy; rx side is always ready.

`ifndef IP_ADDR_WIDTH
`define IP_ADDR_WIDTH 32
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif

module tcp_handshake_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [15:0] RX_WINDOW      = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_val,
  output logic                         start_rdy,
  input  logic [`IP_ADDR_WIDTH-1:0]    start_local_ip,
  input  logic [`IP_ADDR_WIDTH-1:0]    start_remote_ip,
  input  logic [15:0]                  start_local_port,
  input  logic [15:0]                  start_remote_port,
  input  logic [31:0]                  start_isn,
  output logic                         tcp_parser_tx_val,
  input  logic                         parser_tcp_tx_rdy,
  output logic [`IP_ADDR_WIDTH-1:0]    tcp_parser_tx_src_ip,
  output logic [`IP_ADDR_WIDTH-1:0]    tcp_parser_tx_dst_ip,
  output logic [`TCP_HEADER_WIDTH-1:0] tcp_parser_tx_tcp_hdr,
  input  logic                         parser_tcp_rx_hdr_val,
  output logic                         tcp_parser_rx_rdy,
  input  logic [`IP_ADDR_WIDTH-1:0]    parser_tcp_rx_src_ip,
  input  logic [`IP_ADDR_WIDTH-1:0]    parser_tcp_rx_dst_ip,
  input  logic [`TCP_HEADER_WIDTH-1:0] parser_tcp_rx_tcp_hdr,
  output logic                         conn_established,
  output logic                         conn_failed,
  output logic [31:0]                  snd_nxt,
  output logic [31:0]                  rcv_nxt
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; retry counter must hold MAX_RETRIES.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  localparam logic [7:0] FLAG_SYN = 8'h02;
  localparam logic [7:0] FLAG_ACK = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_SYN,
    ST_WAIT_SYNACK,
    ST_SEND_ACK,
    ST_ESTABLISHED,
    ST_FAILED
  } state_t;

  state_t                      state_q, state_d;
  logic [`IP_ADDR_WIDTH-1:0]   local_ip_q, local_ip_d;
  logic [`IP_ADDR_WIDTH-1:0]   remote_ip_q, remote_ip_d;
  logic [15:0]                 local_port_q, local_port_d;
  logic [15:0]                 remote_port_q, remote_port_d;
  logic [31:0]                 isn_q, isn_d;
  logic [31:0]                 rcv_nxt_q, rcv_nxt_d;
  logic [31:0]                 snd_nxt_q, snd_nxt_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [RW-1:0]               retry_q, retry_d;

  // Incoming header fields
  logic [15:0] rx_src_port, rx_dst_port;
  logic [31:0] rx_seq, rx_ack;
  logic        rx_syn, rx_rst, rx_ackf;
  logic        rx_match, rx_synack, rx_rstack;
  logic        unused_rx_bits;

  // Outgoing header fields
  logic [31:0] tx_seq, tx_ack;
  logic [7:0]  tx_flags;
  logic [31:0] isn_plus1;

  assign rx_src_port = parser_tcp_rx_tcp_hdr[159:144];
  assign rx_dst_port = parser_tcp_rx_tcp_hdr[143:128];
  assign rx_seq      = parser_tcp_rx_tcp_hdr[127:96];
  assign rx_ack      = parser_tcp_rx_tcp_hdr[95:64];
  assign rx_ackf     = parser_tcp_rx_tcp_hdr[52];
  assign rx_rst      = parser_tcp_rx_tcp_hdr[50];
  assign rx_syn      = parser_tcp_rx_tcp_hdr[49];

  // Remaining header bits carry nothing the handshake cares about.
  assign unused_rx_bits = ^{parser_tcp_rx_tcp_hdr[63:53], parser_tcp_rx_tcp_hdr[51],
                            parser_tcp_rx_tcp_hdr[48:0]};

  assign isn_plus1 = isn_q + 32'd1;

  // A header belongs to this connection only if the 4-tuple matches and it acknowledges our SYN.
  always_comb begin
    rx_match  = parser_tcp_rx_hdr_val &&
                (state_q == ST_WAIT_SYNACK) &&
                (parser_tcp_rx_src_ip == remote_ip_q) &&
                (parser_tcp_rx_dst_ip == local_ip_q) &&
                (rx_src_port == remote_port_q) &&
                (rx_dst_port == local_port_q) &&
                (rx_ack == isn_plus1);
    rx_synack = rx_match && rx_syn && rx_ackf && !rx_rst;
    rx_rstack = rx_match && rx_rst && rx_ackf;
  end

  // Next-state, counters and transmit header selection.
  always_comb begin
    state_d       = state_q;
    local_ip_d    = local_ip_q;
    remote_ip_d   = remote_ip_q;
    local_port_d  = local_port_q;
    remote_port_d = remote_port_q;
    isn_d         = isn_q;
    rcv_nxt_d     = rcv_nxt_q;
    snd_nxt_d     = snd_nxt_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    start_rdy     = 1'b0;
    tcp_parser_tx_val = 1'b0;
    tx_seq        = 32'd0;
    tx_ack        = 32'd0;
    tx_flags      = 8'd0;

    case (state_q)
      ST_IDLE, ST_ESTABLISHED, ST_FAILED: begin
        start_rdy = 1'b1;
        if (start_val) begin
          local_ip_d    = start_local_ip;
          remote_ip_d   = start_remote_ip;
          local_port_d  = start_local_port;
          remote_port_d = start_remote_port;
          isn_d         = start_isn;
          retry_d       = '0;
          state_d       = ST_SEND_SYN;
        end
      end

      ST_SEND_SYN: begin
        tcp_parser_tx_val = 1'b1;
        tx_seq            = isn_q;
        tx_flags          = FLAG_SYN;
        if (parser_tcp_tx_rdy) begin
          timer_d = '0;
          state_d = ST_WAIT_SYNACK;
        end
      end

      ST_WAIT_SYNACK: begin
        timer_d = timer_q + 1'b1;
        // An accepted reply in the timeout cycle takes priority over retransmit.
        if (rx_synack) begin
          rcv_nxt_d = rx_seq + 32'd1;
          state_d   = ST_SEND_ACK;
        end else if (rx_rstack) begin
          state_d = ST_FAILED;
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND_SYN;
          end else begin
            state_d = ST_FAILED;
          end
        end
      end

      ST_SEND_ACK: begin
        tcp_parser_tx_val = 1'b1;
        tx_seq            = isn_plus1;
        tx_ack            = rcv_nxt_q;
        tx_flags          = FLAG_ACK;
        if (parser_tcp_tx_rdy) begin
          snd_nxt_d = isn_plus1;
          state_d   = ST_ESTABLISHED;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched connection context, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      local_ip_q    <= '0;
      remote_ip_q   <= '0;
      local_port_q  <= '0;
      remote_port_q <= '0;
      isn_q         <= '0;
      rcv_nxt_q     <= '0;
      snd_nxt_q     <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      local_ip_q    <= local_ip_d;
      remote_ip_q   <= remote_ip_d;
      local_port_q  <= local_port_d;
      remote_port_q <= remote_port_d;
      isn_q         <= isn_d;
      rcv_nxt_q     <= rcv_nxt_d;
      snd_nxt_q     <= snd_nxt_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
    end
  end

  // Header is zero whenever nothing is being offered, so idle/reset outputs read as 0.
  always_comb begin
    tcp_parser_tx_tcp_hdr = '0;
    if (tcp_parser_tx_val) begin
      tcp_parser_tx_tcp_hdr = {local_port_q, remote_port_q, tx_seq, tx_ack,
                               4'd5, 4'd0, tx_flags, RX_WINDOW, 16'd0, 16'd0};
    end
  end

  assign tcp_parser_tx_src_ip = local_ip_q;
  assign tcp_parser_tx_dst_ip = remote_ip_q;
  assign tcp_parser_rx_rdy    = 1'b1;
  assign conn_established     = (state_q == ST_ESTABLISHED);
  assign conn_failed          = (state_q == ST_FAILED);
  assign snd_nxt              = snd_nxt_q;
  assign rcv_nxt              = rcv_nxt_q;

endmodule
